mem_bus_arbiter: RTL and testbench

- Shares one single-port SoC memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the core and the memory, replacing direct wiring to the instruction memory.
- Serialises requests with a req/ready handshake and drives the memory port from registers.
- Presents returned data to the winning requester, so IF and LS can both target one unified memory image loaded from a test program.

---
 rtl/mem_bus_arbiter.sv | 113 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (IF / LS) arbiter in front of one single-port memory, req/ready handshake.
// Optional ARB_ROUND_ROBIN_EN: ties alternate masters; otherwise LS has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, nxt;
  logic       gnt_vld;   // a transaction is owned by some master
  logic       gnt_ls;    // owner: 1 = LS, 0 = IF
  logic       last_ls;   // last completed grant: 1 = LS, 0 = IF
  logic [2:0] cnt;
  logic       any_req, pick_ls, take;

  assign any_req = if_req | ls_req;
  assign take    = (state == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // on a tie, hand the bus to whoever did not win last time
  assign pick_ls = ls_req && (!if_req || !last_ls);
`else
  assign pick_ls = ls_req;
`endif

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (any_req) nxt = ISSUE;
      ISSUE: nxt = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:  if (cnt == 3'd1) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state register plus the captured request that drives the memory port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_vld   <= 1'b0;
      gnt_ls    <= 1'b0;
      last_ls   <= 1'b0;
      cnt       <= 3'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      state  <= nxt;
      mem_en <= take;
      if (take) begin
        gnt_vld   <= 1'b1;
        gnt_ls    <= pick_ls;
        mem_addr  <= pick_ls ? ls_addr : if_addr;
        mem_we    <= pick_ls & ls_we;
        mem_wdata <= pick_ls ? ls_wdata : '0;
        mem_wmask <= pick_ls ? ls_wmask : '0;
      end
      // WAIT lasts MEM_LAT-1 cycles; counter counts down to 1
      if (state == ISSUE)     cnt <= 3'(MEM_LAT - 1);
      else if (state == WAIT) cnt <= cnt - 3'd1;
      if (state == RESP) begin
        last_ls <= gnt_ls;
        gnt_vld <= 1'b0;
      end
    end
  end

  // outputs; read data is a gated pass-through of the memory bus
  always_comb begin
    busy     = (state != IDLE);
    if_ready = 1'b0;
    ls_ready = 1'b0;
    if_rdata = '0;
    ls_rdata = '0;
    if (state == RESP && gnt_vld) begin
      if (gnt_ls) begin
        ls_ready = 1'b1;
        if (!mem_we) ls_rdata = mem_rdata;
      end else begin
        if_ready = 1'b1;
        if_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3, each with a small memory model.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---- DUT A, MEM_LAT=1 ----
  logic        rst1, if_req1, if_ready1, ls_req1, ls_we1, ls_ready1;
  logic        mem_en1, mem_we1, busy1;
  logic [63:0] if_addr1, if_rdata1, ls_addr1, ls_wdata1, ls_rdata1;
  logic [63:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic [7:0]  ls_wmask1, mem_wmask1;
  logic [63:0] m1 [0:1023];

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .ls_req(ls_req1), .ls_we(ls_we1), .ls_addr(ls_addr1), .ls_wdata(ls_wdata1),
    .ls_wmask(ls_wmask1), .ls_ready(ls_ready1), .ls_rdata(ls_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_wmask(mem_wmask1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (rst1) begin
      m1[0]   <= 64'h0000_0013_0000_0297;
      m1[512] <= 64'h1111_2222_3333_4444;
    end else if (mem_en1) begin
      mem_rdata1 <= m1[mem_addr1[12:3]];
      if (mem_we1)
        for (int b = 0; b < 8; b++)
          if (mem_wmask1[b]) m1[mem_addr1[12:3]][b*8 +: 8] <= mem_wdata1[b*8 +: 8];
    end
  end

  // ---- DUT B, MEM_LAT=3 ----
  logic        rst3, if_req3, if_ready3, ls_req3, ls_we3, ls_ready3;
  logic        mem_en3, mem_we3, busy3;
  logic [63:0] if_addr3, if_rdata3, ls_addr3, ls_wdata3, ls_rdata3;
  logic [63:0] mem_addr3, mem_wdata3, mem_rdata3;
  logic [7:0]  ls_wmask3, mem_wmask3;
  logic [63:0] m3 [0:3];
  logic [63:0] p3 [0:2];

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
    .ls_wmask(ls_wmask3), .ls_ready(ls_ready3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wmask(mem_wmask3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  always @(posedge clk) begin
    if (rst3) begin
      m3[0] <= 64'h0000_0013_0000_0297;
      m3[1] <= 64'hA5A5_0001_2345_6789;
    end
    p3[0] <= mem_en3 ? m3[mem_addr3[4:3]] : 64'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int en_cnt;
    logic exp_ls, exp_if;
    rst1 = 1; if_req1 = 0; if_addr1 = 0; ls_req1 = 0; ls_we1 = 0; ls_addr1 = 0;
    ls_wdata1 = 0; ls_wmask1 = 0;
    rst3 = 1; if_req3 = 0; if_addr3 = 0; ls_req3 = 0; ls_we3 = 0; ls_addr3 = 0;
    ls_wdata3 = 0; ls_wmask3 = 0;
    tick(); tick();
    chk("rst_busy", busy1, 0);
    chk("rst_mem_en", mem_en1, 0);
    chk("rst_mem_addr", mem_addr1, 0);
    chk("rst_if_ready", if_ready1, 0);
    chk("rst_ls_ready", ls_ready1, 0);
    chk("rst_if_rdata", if_rdata1, 0);
    chk("rst_ls_rdata", ls_rdata1, 0);
    rst1 = 0; rst3 = 0;
    tick();

    // 1: IF fetch, MEM_LAT=1
    if_req1 = 1; if_addr1 = 64'h8000_0000;
    chk("t1_idle_busy", busy1, 0);
    tick();
    chk("t1_mem_en", mem_en1, 1);
    chk("t1_mem_addr", mem_addr1, 64'h8000_0000);
    chk("t1_mem_we", mem_we1, 0);
    chk("t1_busy_t1", busy1, 1);
    chk("t1_if_ready_early", if_ready1, 0);
    tick();
    chk("t1_if_ready", if_ready1, 1);
    chk("t1_if_rdata", if_rdata1, 64'h0000_0013_0000_0297);
    chk("t1_mem_en_off", mem_en1, 0);
    chk("t1_busy_t2", busy1, 1);
    chk("t1_ls_ready", ls_ready1, 0);
    if_req1 = 0;
    tick();
    chk("t1_if_ready_drop", if_ready1, 0);
    chk("t1_if_rdata_zero", if_rdata1, 0);
    chk("t1_busy_end", busy1, 0);

    // 2: LS partial write
    ls_req1 = 1; ls_we1 = 1; ls_addr1 = 64'h8000_1000;
    ls_wdata1 = 64'hDEAD_BEEF_CAFE_F00D; ls_wmask1 = 8'h0F;
    tick();
    chk("t2_mem_en", mem_en1, 1);
    chk("t2_mem_we", mem_we1, 1);
    chk("t2_mem_wmask", mem_wmask1, 8'h0F);
    chk("t2_mem_wdata", mem_wdata1, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t2_mem_addr", mem_addr1, 64'h8000_1000);
    tick();
    chk("t2_ls_ready", ls_ready1, 1);
    chk("t2_ls_rdata", ls_rdata1, 0);
    ls_req1 = 0; ls_we1 = 0; ls_wmask1 = 0;
    tick();
    chk("t2_mem_word", m1[512], 64'h1111_2222_CAFE_F00D);
    chk("t2_ls_ready_drop", ls_ready1, 0);

    // 3/4: continuous contention from reset (memory reloads on reset)
    rst1 = 1; tick(); rst1 = 0; tick();
    if_req1 = 1; if_addr1 = 64'h8000_0000;
    ls_req1 = 1; ls_we1 = 0; ls_addr1 = 64'h8000_1000;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_ls = (c % 3 == 2) && ((c / 3) % 2 == 0);
      exp_if = (c % 3 == 2) && ((c / 3) % 2 == 1);
`else
      exp_ls = (c % 3 == 2);
      exp_if = 1'b0;
`endif
      chk($sformatf("t3_ls_ready_c%0d", c), ls_ready1, exp_ls);
      chk($sformatf("t3_if_ready_c%0d", c), if_ready1, exp_if);
      if (exp_ls) chk($sformatf("t3_ls_rdata_c%0d", c), ls_rdata1, 64'h1111_2222_3333_4444);
      if (exp_if) chk($sformatf("t3_if_rdata_c%0d", c), if_rdata1, 64'h0000_0013_0000_0297);
    end
    if_req1 = 0; ls_req1 = 0;
    tick();
    chk("t3_busy_end", busy1, 0);

    // 5: LS read with MEM_LAT=3
    en_cnt = 0;
    ls_req3 = 1; ls_we3 = 0; ls_addr3 = 64'h8000_0008;
    tick();
    en_cnt += int'(mem_en3);
    chk("t5_mem_en", mem_en3, 1);
    chk("t5_mem_addr", mem_addr3, 64'h8000_0008);
    tick(); en_cnt += int'(mem_en3);
    chk("t5_ready_t2", ls_ready3, 0);
    chk("t5_busy_t2", busy3, 1);
    tick(); en_cnt += int'(mem_en3);
    chk("t5_ready_t3", ls_ready3, 0);
    tick(); en_cnt += int'(mem_en3);
    chk("t5_ls_ready", ls_ready3, 1);
    chk("t5_ls_rdata", ls_rdata3, 64'hA5A5_0001_2345_6789);
    ls_req3 = 0;
    tick(); en_cnt += int'(mem_en3);
    chk("t5_ready_drop", ls_ready3, 0);
    chk("t5_busy_end", busy3, 0);
    chk("t5_mem_en_once", en_cnt, 1);

    // 6: reset in WAIT drops the transaction
    if_req3 = 1; if_addr3 = 64'h8000_0000;
    tick(); tick();
    chk("t6_busy_wait", busy3, 1);
    rst3 = 1; if_req3 = 0;
    tick();
    chk("t6_busy_after_rst", busy3, 0);
    chk("t6_no_ready_rst", if_ready3, 0);
    rst3 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t6_no_ready_c%0d", c), if_ready3, 0);
    end
    if_req3 = 1;
    tick();
    chk("t6_mem_en", mem_en3, 1);
    tick(); tick();
    chk("t6_ready_early", if_ready3, 0);
    tick();
    chk("t6_if_ready", if_ready3, 1);
    chk("t6_if_rdata", if_rdata3, 64'h0000_0013_0000_0297);
    if_req3 = 0;
    tick();
    chk("t6_busy_end", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
